// File: rtl/mmp_iddmm_ctrl_if.sv
// Control bus between the IDDMM sequencer and its PE / A-RAM / final-subtract neighbours.
// The master side is the sequencer; the slave side observes strobes and drives start.
interface mmp_iddmm_ctrl_if #(
    parameter int N = 32
);
    localparam int I_W = $clog2(N);
    localparam int J_W = $clog2(N) + 1;

    logic           start;
    logic           busy;
    logic           done;
    logic [I_W-1:0] i;
    logic [J_W-1:0] j;
    logic           ctl_carry_clr;
    logic           ctl_carry_ena;
    logic           ctl_carry_sel;
    logic           ctl_c_pre_clr;
    logic           ctl_q_ena;
    logic           wr_a_ena;
    logic [J_W-1:0] wr_a_addr;
    logic           wr_carry;

    modport master (
        input  start,
        output busy, done, i, j,
        output ctl_carry_clr, ctl_carry_ena, ctl_carry_sel, ctl_c_pre_clr, ctl_q_ena,
        output wr_a_ena, wr_a_addr, wr_carry
    );

    modport slave (
        output start,
        input  busy, done, i, j,
        input  ctl_carry_clr, ctl_carry_ena, ctl_carry_sel, ctl_c_pre_clr, ctl_q_ena,
        input  wr_a_ena, wr_a_addr, wr_carry
    );
endinterface

// File: rtl/mmp_iddmm_ctrl.sv
// Sequencer for one IDDMM PE: walks i/j over N rows of N+2 cycles, delays j by the PE
// latency to place uj write-backs, then writes the final carry word and pulses done.
module mmp_iddmm_ctrl #(
    parameter int N       = 32,
    parameter int LATENCY = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    mmp_iddmm_ctrl_if.master  ctl
);
    localparam int I_W = $clog2(N);
    localparam int J_W = $clog2(N) + 1;
    localparam logic [I_W-1:0] I_LAST     = I_W'(N - 1);
    localparam logic [J_W-1:0] J_LAST     = J_W'(N);
    localparam logic [5:0]     DRAIN_LAST = 6'((LATENCY > 0) ? LATENCY - 1 : 0);

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, CARRY, DONE} state_t;

    state_t         state_reg;
    logic [I_W-1:0] i_reg;
    logic [J_W-1:0] j_reg;
    logic           j00_reg;
    logic [5:0]     drain_cnt_reg;

    logic           issuing;
    logic           valid_d;
    logic [J_W-1:0] j_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            i_reg         <= '0;
            j_reg         <= '0;
            j00_reg       <= 1'b0;
            drain_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (ctl.start) begin
                        state_reg <= ISSUE;
                        i_reg     <= '0;
                        j_reg     <= '0;
                        j00_reg   <= 1'b1;
                    end
                end
                ISSUE: begin
                    // Q-phase holds j at 0 for one extra cycle before the j=0..N sweep
                    if (j00_reg) begin
                        j00_reg <= 1'b0;
                    end else if (j_reg == J_LAST) begin
                        j_reg <= '0;
                        if (i_reg == I_LAST) begin
                            i_reg         <= '0;
                            drain_cnt_reg <= '0;
                            state_reg     <= (LATENCY == 0) ? CARRY : DRAIN;
                        end else begin
                            i_reg   <= i_reg + I_W'(1);
                            j00_reg <= 1'b1;
                        end
                    end else begin
                        j_reg <= j_reg + J_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt_reg == DRAIN_LAST) begin
                        state_reg <= CARRY;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg + 6'd1;
                    end
                end
                CARRY:   state_reg <= DONE;
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign issuing = (state_reg == ISSUE);

    // Delay line matching the PE pipeline so uj lands at the column that produced it
    generate
        if (LATENCY == 0) begin : g_no_delay
            assign valid_d = issuing;
            assign j_d     = j_reg;
        end else begin : g_delay
            logic           valid_sr [LATENCY];
            logic [J_W-1:0] j_sr     [LATENCY];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < LATENCY; k++) begin
                        valid_sr[k] <= 1'b0;
                        j_sr[k]     <= '0;
                    end
                end else begin
                    valid_sr[0] <= issuing;
                    j_sr[0]     <= j_reg;
                    for (int k = 1; k < LATENCY; k++) begin
                        valid_sr[k] <= valid_sr[k-1];
                        j_sr[k]     <= j_sr[k-1];
                    end
                end
            end

            assign valid_d = valid_sr[LATENCY-1];
            assign j_d     = j_sr[LATENCY-1];
        end
    endgenerate

    assign ctl.busy          = (state_reg == ISSUE) || (state_reg == DRAIN) || (state_reg == CARRY);
    assign ctl.done          = (state_reg == DONE);
    assign ctl.i             = i_reg;
    assign ctl.j             = j_reg;
    assign ctl.ctl_carry_clr = issuing && (i_reg == '0) && (j_reg == '0);
    assign ctl.ctl_carry_ena = issuing && (j_reg == J_LAST);
    assign ctl.ctl_carry_sel = issuing && (j_reg == J_LAST);
    assign ctl.ctl_c_pre_clr = issuing && (j_reg == '0) && j00_reg;
    assign ctl.ctl_q_ena     = issuing && (j_reg == '0) && j00_reg;
    assign ctl.wr_carry      = (state_reg == CARRY);
    assign ctl.wr_a_ena      = valid_d && (j_d != '0);
    assign ctl.wr_a_addr     = (state_reg == CARRY) ? J_LAST :
                               (ctl.wr_a_ena ? (j_d - J_W'(1)) : '0);
endmodule

// File: doc/mmp_iddmm_ctrl.md
Name: mmp_iddmm_ctrl

Overview:
- Sequencer that drives one mmp_iddmm_pe through a full N-word IDDMM multiplication (x*y*2^(-K*N) mod m, before final subtraction).
- Generates word indices i/j and the five PE control strobes.
- Tracks PE pipeline latency so that write-backs of uj into the A-word RAM land at the correct address.
- Issues a final carry write into word N, then signals done to the downstream final-subtract stage.

Parameters:
- N, 32, number of K-bit words per operand.
- LATENCY, 16, PE pipeline depth in cycles (L1+L2+L3+L4+D5); legal range 0..63.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a multiplication; sampled only in IDLE
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse when A RAM holds the complete result
- i  output  $clog2(N)  row index; selects yi
- j  output  $clog2(N)+1  column index; selects xj, mj, aj
- ctl_carry_clr  output  1  to PE
- ctl_carry_ena  output  1  to PE
- ctl_carry_sel  output  1  to PE
- ctl_c_pre_clr  output  1  to PE
- ctl_q_ena  output  1  to PE
- wr_a_ena  output  1  A RAM write strobe; data is PE uj
- wr_a_addr  output  $clog2(N)+1  A RAM write address
- wr_carry  output  1  one-cycle strobe: write {zeros, PE carry} to A word N

Behaviour:
- States: IDLE, ISSUE, DRAIN, CARRY, DONE. Reset (asynchronous, any time, including mid-operation) forces IDLE, i=0, j=0, and clears the delay line; all outputs are 0.
- IDLE: when start=1, go to ISSUE next cycle with i=0, j=0, phase=Q.
- Row sequencing (ISSUE): each row is N+2 cycles.
  - Cycle 1: Q-phase, j=0, j00=1.
  - Cycles 2..N+2: j=0,1,...,N, with j00=0.
  - After the j=N cycle: if i<N-1, increment i and start the next row at its Q-phase. If i=N-1, go to DRAIN.
- Strobes are combinational from the registered i/j/j00/state and are valid only in ISSUE (0 elsewhere):
  - ctl_carry_clr = (i==0 && j==0)
  - ctl_carry_ena = ctl_carry_sel = (j==N)
  - ctl_c_pre_clr = ctl_q_ena = (j==0 && j00)
- Delay line: a LATENCY-deep shift register of {valid, j}. valid=1 only for issue cycles.
  - wr_a_ena = valid_d && j_d!=0
  - wr_a_addr = j_d-1
  - With LATENCY=0 these are combinational from the current cycle.
- DRAIN: lasts exactly LATENCY cycles so the final write (addr N-1) completes, then go to CARRY.
- CARRY: one cycle; wr_carry=1, wr_a_addr=N, wr_a_ena=0. Then go to DONE.
- DONE: done=1 for one cycle, busy=0 in the same cycle, then return to IDLE.
- start while not in IDLE is ignored.
- Timing: with start accepted at cycle 0, issue occupies cycles 1..N(N+2). The last uj write occurs at N(N+2)+LATENCY, wr_carry at +1 after that, and done at +2.
- Each row writes addresses 0..N-1 exactly once each, in ascending order.

Test Plan:
- N=4, LATENCY=3, single start: done at cycle 29, wr_carry at cycle 28, exactly 16 uj writes, last write (addr 3) at cycle 27, busy high cycles 1..28.
- N=4, LATENCY=3 strobe check: ctl_q_ena high at cycles 1, 7, 13, 19; ctl_carry_ena high at 6, 12, 18, 24; ctl_carry_clr high at cycles 1 and 2 only.
- LATENCY=0, N=4: writes coincide with issue j=1..4 and carry addr 0..3; done at cycle 26.
- Reset asserted at cycle 10 mid-run: all outputs 0 immediately (asynchronous). A start after release runs a full clean sequence with 16 writes.
- start pulsed at cycles 0 and 5: second pulse ignored, one done only. start held high continuously: back-to-back runs with IDLE sampling one cycle after done.
- Full system, N=32, K=128, LATENCY=16 with PE, A RAM and final subtract: result equals the golden x*y*R^-1 mod m for the standard test vectors.
